// File: rtl/bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bridge_pkg
//  Description : Shared ASCII constants, parser states and hex decode for the
//                ASCII bus bridge (receiver now, transmitter later).
//  Revision    : 1.0 - initial release
// ============================================================================
package bridge_pkg;

  localparam logic [7:0] c_ascii_r  = 8'h52;
  localparam logic [7:0] c_ascii_w  = 8'h57;
  localparam logic [7:0] c_ascii_cr = 8'h0D;
  localparam logic [7:0] c_ascii_lf = 8'h0A;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_TERM = 2'd3
  } state_t;

  // Returns {valid, nibble}; letters of either case map onto 10..15.
  function automatic logic [4:0] hex_to_nibble(input logic [7:0] b);
    logic [4:0] r;
    r = 5'd0;
    if (b >= 8'h30 && b <= 8'h39) begin
      r = {1'b1, b[3:0]};
    end else if ((b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66)) begin
      r = {1'b1, b[3:0] + 4'd9};
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bridge_rx.sv
`default_nettype none
// ============================================================================
//  Module      : bridge_rx
//  Description : Parses ASCII "Raaaa<CR|LF>" / "Waaaadddd<CR|LF>" messages
//                into single-cycle bus transactions.
//  Revision    : 1.0 - initial release
// ============================================================================
module bridge_rx
  import bridge_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  data_i,
  input  logic        valid_i,
  output logic [15:0] addr_o,
  output logic [15:0] data_o,
  output logic        rw_o,
  output logic        valid_o
);

  state_t      r_state;
  logic [1:0]  r_cnt;
  logic        r_rw;
  logic [15:0] r_addr;
  logic [15:0] r_data;

  logic [4:0]  w_hex;
  logic        w_is_start;
  logic        w_is_term;

  assign w_hex      = hex_to_nibble(data_i);
  assign w_is_start = (data_i == c_ascii_r) || (data_i == c_ascii_w);
  assign w_is_term  = (data_i == c_ascii_cr) || (data_i == c_ascii_lf);

  // Message fields are assembled in r_* and only copied to the outputs on a
  // good terminator, so the outputs hold the last emitted transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 2'd0;
      r_rw    <= 1'b0;
      r_addr  <= 16'h0000;
      r_data  <= 16'h0000;
      addr_o  <= 16'h0000;
      data_o  <= 16'h0000;
      rw_o    <= 1'b0;
      valid_o <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (valid_i) begin
        if (w_is_start) begin
          r_state <= ST_ADDR;
          r_cnt   <= 2'd0;
          r_rw    <= (data_i == c_ascii_w);
          r_data  <= 16'h0000;
        end else begin
          case (r_state)
            ST_IDLE: r_state <= ST_IDLE;
            ST_ADDR: begin
              if (w_hex[4]) begin
                r_addr <= {r_addr[11:0], w_hex[3:0]};
                r_cnt  <= r_cnt + 2'd1;
                if (r_cnt == 2'd3) begin
                  r_state <= r_rw ? ST_DATA : ST_TERM;
                end
              end else begin
                r_state <= ST_IDLE;
                r_cnt   <= 2'd0;
              end
            end
            ST_DATA: begin
              if (w_hex[4]) begin
                r_data <= {r_data[11:0], w_hex[3:0]};
                r_cnt  <= r_cnt + 2'd1;
                if (r_cnt == 2'd3) begin
                  r_state <= ST_TERM;
                end
              end else begin
                r_state <= ST_IDLE;
                r_cnt   <= 2'd0;
              end
            end
            ST_TERM: begin
              if (w_is_term) begin
                addr_o  <= r_addr;
                data_o  <= r_rw ? r_data : 16'h0000;
                rw_o    <= r_rw;
                valid_o <= 1'b1;
              end
              r_state <= ST_IDLE;
              r_cnt   <= 2'd0;
            end
            default: r_state <= ST_IDLE;
          endcase
        end
      end
    end
  end

endmodule
`default_nettype wire
